// File: rtl/memory_controller_interface_pkg.sv
// Shared request/response types for the CPU-to-main-memory path, plus arbiter
// state and port-id types. Types only; no logic, no latency, no backpressure.
package memory_controller_interface;

    typedef struct packed {
        logic        valid;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } mci_request_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] rdata;
    } mci_response_t;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_ISSUE   = 2'd1,
        ARB_RESPOND = 2'd2
    } arb_state_e;

    typedef enum logic {
        PORT1 = 1'b0,
        PORT2 = 1'b1
    } mci_port_e;

endpackage

// File: rtl/mci_port_arbiter.sv
// Two-port (icache/dcache) to single main-memory arbiter, one transaction in flight.
// Grant edge + memory latency + one RESPOND cycle; requesters hold requests until their res.valid pulse.
module mci_port_arbiter
    import memory_controller_interface::*;
#(
    parameter int PRIORITY_MODE = 0
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  mci_request_t  mem_req_port1,
    output mci_response_t mem_res_port1,
    input  mci_request_t  mem_req_port2,
    output mci_response_t mem_res_port2,
    output mci_request_t  mem_req,
    input  mci_response_t mem_res
);

    arb_state_e   state_q, state_d;
    mci_port_e    last_grant_q, last_grant_d;
    mci_request_t mem_req_q, mem_req_d;
    logic [31:0]  rdata_q, rdata_d;
    logic         res1_vld_q, res1_vld_d;
    logic         res2_vld_q, res2_vld_d;
    mci_port_e    win;

    // Round-robin favours the port not granted last; fixed mode always favours the data port.
    function automatic mci_port_e sel_grant(input logic v1, input logic v2, input mci_port_e last);
        mci_port_e g;
        if (v1 && v2) begin
            if (PRIORITY_MODE == 1)
                g = PORT2;
            else
                g = (last == PORT1) ? PORT2 : PORT1;
        end else begin
            g = v2 ? PORT2 : PORT1;
        end
        return g;
    endfunction

    assign win = sel_grant(mem_req_port1.valid, mem_req_port2.valid, last_grant_q);

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        mem_req_d    = mem_req_q;
        rdata_d      = rdata_q;
        res1_vld_d   = 1'b0;
        res2_vld_d   = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (mem_req_port1.valid || mem_req_port2.valid) begin
                    last_grant_d = win;
                    mem_req_d    = (win == PORT2) ? mem_req_port2 : mem_req_port1;
                    state_d      = ARB_ISSUE;
                end
            end
            ARB_ISSUE: begin
                if (mem_res.valid) begin
                    rdata_d         = mem_res.rdata;
                    mem_req_d.valid = 1'b0;
                    res1_vld_d      = (last_grant_q == PORT1);
                    res2_vld_d      = (last_grant_q == PORT2);
                    state_d         = ARB_RESPOND;
                end
            end
            ARB_RESPOND: state_d = ARB_IDLE;
            default:     state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q      <= ARB_IDLE;
            last_grant_q <= PORT1;
            mem_req_q    <= '0;
            rdata_q      <= '0;
            res1_vld_q   <= 1'b0;
            res2_vld_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            mem_req_q    <= mem_req_d;
            rdata_q      <= rdata_d;
            res1_vld_q   <= res1_vld_d;
            res2_vld_q   <= res2_vld_d;
        end
    end

    assign mem_req       = mem_req_q;
    assign mem_res_port1 = '{valid: res1_vld_q, rdata: rdata_q};
    assign mem_res_port2 = '{valid: res2_vld_q, rdata: rdata_q};

endmodule

// File: tb/tb_mci_port_arbiter.sv
// Directed bench for mci_port_arbiter: a round-robin instance and a fixed-priority instance.
// Inputs are driven and outputs sampled on the falling clock edge.
`timescale 1ns/1ps
module tb_mci_port_arbiter;
    import memory_controller_interface::*;

    logic clk;
    logic rst;

    mci_request_t  req1_a [2];
    mci_request_t  req2_a [2];
    mci_response_t mres_a [2];
    mci_request_t  mreq_a [2];
    mci_response_t res1_a [2];
    mci_response_t res2_a [2];

    int checks   = 0;
    int failures = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    mci_port_arbiter #(.PRIORITY_MODE(0)) u_rr (
        .i_clk(clk), .i_reset(rst),
        .mem_req_port1(req1_a[0]), .mem_res_port1(res1_a[0]),
        .mem_req_port2(req2_a[0]), .mem_res_port2(res2_a[0]),
        .mem_req(mreq_a[0]), .mem_res(mres_a[0])
    );

    mci_port_arbiter #(.PRIORITY_MODE(1)) u_fp (
        .i_clk(clk), .i_reset(rst),
        .mem_req_port1(req1_a[1]), .mem_res_port1(res1_a[1]),
        .mem_req_port2(req2_a[1]), .mem_res_port2(res2_a[1]),
        .mem_req(mreq_a[1]), .mem_res(mres_a[1])
    );

    task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic mci_request_t mk_req(input logic we, input logic [31:0] addr,
                                            input logic [31:0] wdata, input logic [3:0] wstrb);
        mci_request_t r;
        r.valid = 1'b1;
        r.we    = we;
        r.addr  = addr;
        r.wdata = wdata;
        r.wstrb = wstrb;
        return r;
    endfunction

    // Waits for the grant, checks the forwarded request and its stability, answers after
    // lat idle cycles, then checks the response pulse. Returns at the RESPOND-cycle negedge.
    task automatic serve(input string tag, input int k, input int port, input mci_request_t exp_req,
                         input logic [31:0] rd, input int lat, input bit chk_rd, output int waited);
        mci_response_t pr;
        mci_response_t po;
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
            if (waited == 1)
                chk({tag, "_res_idle"}, 72'(res1_a[k].valid | res2_a[k].valid), 72'(0));
        end while (!mreq_a[k].valid && waited < 20);
        if (!mreq_a[k].valid) begin
            chk({tag, "_grant_timeout"}, 72'(0), 72'(1));
            return;
        end
        chk({tag, "_req"}, 72'(mreq_a[k]), 72'(exp_req));
        repeat (lat) begin
            @(negedge clk);
            chk({tag, "_hold"}, 72'(mreq_a[k]), 72'(exp_req));
        end
        mres_a[k] = '{valid: 1'b1, rdata: rd};
        @(negedge clk);
        mres_a[k] = '0;
        pr = (port == 2) ? res2_a[k] : res1_a[k];
        po = (port == 2) ? res1_a[k] : res2_a[k];
        chk({tag, "_pulse_vld"}, 72'(pr.valid), 72'(1));
        if (chk_rd)
            chk({tag, "_rdata"}, 72'(pr.rdata), 72'(rd));
        chk({tag, "_other_vld"}, 72'(po.valid), 72'(0));
        chk({tag, "_memreq_drop"}, 72'(mreq_a[k].valid), 72'(0));
    endtask

    initial begin
        int w;
        int n;
        mci_request_t r1;
        mci_request_t r2;

        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            req1_a[k] = '0;
            req2_a[k] = '0;
            mres_a[k] = '0;
        end
        repeat (2) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk("reset_memreq", 72'(mreq_a[k]), 72'(0));
            chk("reset_res1", 72'(res1_a[k]), 72'(0));
            chk("reset_res2", 72'(res2_a[k]), 72'(0));
        end
        rst = 1'b0;

        // Single port1 read, memory answers after 3 cycles
        req1_a[0] = mk_req(1'b0, 32'h100, 32'h0, 4'h0);
        serve("rd1", 0, 1, mk_req(1'b0, 32'h100, 32'h0, 4'h0), 32'hDEADBEEF, 3, 1'b1, w);
        chk("rd1_latency", 72'(w), 72'(1));
        req1_a[0] = '0;
        @(negedge clk);
        chk("rd1_pulse_end", 72'(res1_a[0].valid), 72'(0));

        // Spurious memory response while idle
        mres_a[0] = '{valid: 1'b1, rdata: 32'hBAD0BAD0};
        @(negedge clk);
        mres_a[0] = '0;
        repeat (2) begin
            chk("spur_memreq", 72'(mreq_a[0].valid), 72'(0));
            chk("spur_res", 72'(res1_a[0].valid | res2_a[0].valid), 72'(0));
            @(negedge clk);
        end

        // Port2 write
        req2_a[0] = mk_req(1'b1, 32'h40, 32'h12345678, 4'hF);
        serve("wr2", 0, 2, mk_req(1'b1, 32'h40, 32'h12345678, 4'hF), 32'h0, 2, 1'b0, w);
        chk("wr2_latency", 72'(w), 72'(1));
        req2_a[0] = '0;

        // Continuous contention after reset: 2,1,2,1,2,1
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        r1 = mk_req(1'b0, 32'h1000, 32'h0, 4'h0);
        r2 = mk_req(1'b0, 32'h2000, 32'h0, 4'h0);
        req1_a[0] = r1;
        req2_a[0] = r2;
        for (int i = 0; i < 6; i++) begin
            if (i % 2 == 0) begin
                serve($sformatf("rr%0d_p2", i), 0, 2, r2, 32'hA0 + i, 1, 1'b1, w);
                r2.addr = r2.addr + 32'h4;
                req2_a[0] = r2;
            end else begin
                serve($sformatf("rr%0d_p1", i), 0, 1, r1, 32'hA0 + i, 1, 1'b1, w);
                r1.addr = r1.addr + 32'h4;
                req1_a[0] = r1;
            end
            if (i > 0)
                chk($sformatf("rr%0d_b2b_wait", i), 72'(w), 72'(2));
        end
        req1_a[0] = '0;
        req2_a[0] = '0;

        // Reset in the middle of ISSUE, then a stale memory response
        req1_a[0] = mk_req(1'b0, 32'h200, 32'h0, 4'h0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!mreq_a[0].valid && n < 20);
        chk("rst_issue_granted", 72'(mreq_a[0].valid), 72'(1));
        @(negedge clk);
        rst = 1'b1;
        req1_a[0] = '0;
        #1;
        chk("rst_issue_memreq", 72'(mreq_a[0]), 72'(0));
        chk("rst_issue_res1", 72'(res1_a[0]), 72'(0));
        chk("rst_issue_res2", 72'(res2_a[0]), 72'(0));
        @(negedge clk);
        rst = 1'b0;
        mres_a[0] = '{valid: 1'b1, rdata: 32'hCAFEF00D};
        @(negedge clk);
        mres_a[0] = '0;
        chk("stale_res1", 72'(res1_a[0].valid), 72'(0));
        chk("stale_memreq", 72'(mreq_a[0].valid), 72'(0));
        @(negedge clk);
        chk("stale_res1_late", 72'(res1_a[0].valid), 72'(0));
        req1_a[0] = mk_req(1'b0, 32'h300, 32'h0, 4'h0);
        serve("post_rst", 0, 1, mk_req(1'b0, 32'h300, 32'h0, 4'h0), 32'h55AA55AA, 1, 1'b1, w);
        chk("post_rst_latency", 72'(w), 72'(1));
        req1_a[0] = '0;

        // Fixed priority: port2 keeps winning while it requests
        r1 = mk_req(1'b0, 32'h500, 32'h0, 4'h0);
        r2 = mk_req(1'b0, 32'h600, 32'h0, 4'h0);
        req1_a[1] = r1;
        req2_a[1] = r2;
        for (int i = 0; i < 3; i++) begin
            serve($sformatf("fp%0d_p2", i), 1, 2, r2, 32'hB0 + i, 1, 1'b1, w);
            r2.addr = r2.addr + 32'h4;
            req2_a[1] = r2;
        end
        req2_a[1] = '0;
        serve("fp_p1", 1, 1, r1, 32'hC1, 1, 1'b1, w);
        req1_a[1] = '0;
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

endmodule
